gf180mcu_fd_sc_mcu9t5v0__in2_bist: RTL and testbench
====================================================

// Module: gf180mcu_fd_sc_mcu9t5v0__in2_bist
// PURPOSE
//  Built-in self-test initiator for 2-input combinational library cells (and2, or2, nand2, xor2...).
//  Drives A1/A2 of a cell-under-test, samples the cell's Z after a settle window and compares it with
//  a programmed 4-entry truth table. Sweeps all vectors PASSES times, counts mismatches, reports the
//  first failing vector. Sits beside a cell instance in library silicon/FPGA test harnesses.
// PARAMETERS
//  SETTLE  1  extra cycles each vector is held before Z is sampled (hold = SETTLE+1 cycles, >=0)
//  PASSES  1  number of full 4-vector sweeps per run (>=1)
//  ERR_W   4  width of saturating mismatch counter
// PORTS
//  CLK       in   1      rising-edge clock
//  RN        in   1      asynchronous active-low reset
//  START     in   1      run request, sampled in IDLE/DONE only
//  ABORT     in   1      synchronous abort, returns to IDLE
//  TRUTH     in   4      expected Z, index {A1,A2} (AND2 = 4'b1000), latched at START
//  Z         in   1      output of cell-under-test (combinational from A1/A2)
//  A1        out  1      drive to cell-under-test input A1 (registered)
//  A2        out  1      drive to cell-under-test input A2 (registered)
//  BUSY      out  1      run in progress
//  DONE      out  1      run completed, held until next START/ABORT/reset
//  PASS      out  1      DONE and ERR_CNT==0
//  ERR_CNT   out  ERR_W  mismatch count, saturates at all-ones
//  FAIL_VEC  out  2      {A1,A2} of first mismatch; valid when DONE && !PASS
//  VDD/VSS   inout 1     power pins, present only under USE_POWER_PINS
// BEHAVIOUR
//  Reset (RN=0, async): state IDLE; A1,A2,BUSY,DONE,PASS=0; ERR_CNT=0; FAIL_VEC=0; counters 0.
//  States: IDLE -> RUN (START) -> DONE (last sample) -> RUN (START) ; any -> IDLE (ABORT).
//  Edge e0 with START in IDLE/DONE: latch TRUTH; {A1,A2}<=2'b00; BUSY<=1; DONE,PASS<=0; ERR_CNT<=0;
//   FAIL_VEC<=0; settle cnt<=0; pass cnt<=0.
//  RUN, each edge: if cnt<SETTLE then cnt++; else sample Z, compare with TRUTH[{A1,A2}], cnt<=0,
//   {A1,A2}<={A1,A2}+1 (wraps 11->00, pass cnt++).
//  Samples occur at edges e0+k*(SETTLE+1), k=1..4*PASSES; vector order 00,01,10,11 per sweep.
//  Mismatch: ERR_CNT++ unless all-ones (saturate); FAIL_VEC<=vector only on first mismatch of run.
//  Final sample edge (k=4*PASSES): its compare is included; BUSY<=0; DONE<=1; {A1,A2}<=00;
//   PASS<=1 iff no mismatch in run (incl. this sample). START-to-DONE = 4*PASSES*(SETTLE+1) cycles.
//  START while BUSY: ignored. START and ABORT same edge: ABORT wins.
//  ABORT (any state): next edge IDLE; BUSY,DONE,PASS,A1,A2<=0; ERR_CNT/FAIL_VEC keep values.
//  DONE state: outputs frozen; A1/A2 held 00; Z ignored.
//  Reset mid-run: immediate return to reset values; no partial DONE.
//  Z sampled only at compare edges; glitches between compares have no effect.
// TESTING
//  1 SETTLE=1,PASSES=1,TRUTH=4'b1000, Z=A1&A2 -> A1A2 00,01,10,11 each 2 cycles; DONE at e0+8;
//    PASS=1, ERR_CNT=0.
//  2 Same, Z tied 0 -> DONE at e0+8; ERR_CNT=1, FAIL_VEC=2'b11, PASS=0.
//  3 ERR_W=2,PASSES=4,SETTLE=0,TRUTH=4'b1000, Z=~(A1&A2) -> 16 mismatches; ERR_CNT saturates at 3;
//    FAIL_VEC=2'b00; DONE at e0+16.
//  4 RN low at e0+5 of test 1 -> all outputs 0 immediately; later START gives clean run, PASS=1.
//  5 START pulsed at e0+3 (busy) -> ignored, DONE still at e0+8; ABORT at e0+4 -> IDLE at e0+5,
//    DONE=0, A1=A2=0; START and ABORT together in IDLE -> stays IDLE.
//  6 TRUTH=4'b0110, Z=A1^A2, two back-to-back runs via START in DONE -> both PASS=1; counters cleared.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__in2_bist.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__in2_bist.sv - BIST initiator for 2-input combinational library cells
// Sweeps {A1,A2} through 00..11, checks Z against a latched truth table, reports errors.
module gf180mcu_fd_sc_mcu9t5v0__in2_bist #(
    parameter int SETTLE = 1,
    parameter int PASSES = 1,
    parameter int ERR_W  = 4
) (
`ifdef USE_POWER_PINS
    inout  wire               VDD,
    inout  wire               VSS,
`endif
    input  logic              CLK,
    input  logic              RN,
    input  logic              START,
    input  logic              ABORT,
    input  logic [3:0]        TRUTH,
    input  logic              Z,
    output logic              A1,
    output logic              A2,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [1:0]        FAIL_VEC
);

    localparam int SC_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SC_W-1:0]  SETTLE_V   = SC_W'(SETTLE);
    localparam logic [PC_W-1:0]  LAST_PASS  = PC_W'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         truth_q, truth_d;
    logic [1:0]         vec_q, vec_d;
    logic [SC_W-1:0]    scnt_q, scnt_d;
    logic [PC_W-1:0]    pcnt_q, pcnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [1:0]         fvec_q, fvec_d;
    logic               seen_q, seen_d;

    logic               mismatch;
    logic               last_sample;

    assign mismatch    = (Z != truth_q[vec_q]);
    assign last_sample = (vec_q == 2'b11) && (pcnt_q == LAST_PASS);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            truth_q <= 4'b0000;
            vec_q   <= 2'b00;
            scnt_q  <= '0;
            pcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= 2'b00;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            truth_q <= truth_d;
            vec_q   <= vec_d;
            scnt_q  <= scnt_d;
            pcnt_q  <= pcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        truth_d = truth_q;
        vec_d   = vec_q;
        scnt_d  = scnt_q;
        pcnt_d  = pcnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        seen_d  = seen_q;

        if (ABORT) begin
            // Error count and first failing vector stay visible after an abort.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            vec_d   = 2'b00;
            scnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d = ST_RUN;
                        truth_d = TRUTH;
                        vec_d   = 2'b00;
                        scnt_d  = '0;
                        pcnt_d  = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        err_d   = '0;
                        fvec_d  = 2'b00;
                        seen_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (scnt_q != SETTLE_V) begin
                        scnt_d = scnt_q + SC_W'(1);
                    end else begin
                        scnt_d = '0;
                        if (mismatch) begin
                            if (err_q != ERR_MAX) begin
                                err_d = err_q + ERR_W'(1);
                            end
                            if (!seen_q) begin
                                fvec_d = vec_q;
                            end
                            seen_d = 1'b1;
                        end
                        if (last_sample) begin
                            state_d = ST_DONE;
                            vec_d   = 2'b00;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = !(seen_q || mismatch);
                        end else begin
                            vec_d = vec_q + 2'b01;
                            if (vec_q == 2'b11) begin
                                pcnt_d = pcnt_q + PC_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = 2'b00;
                end
            endcase
        end
    end

    assign A1       = vec_q[1];
    assign A2       = vec_q[0];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__in2_bist.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__in2_bist.sv - directed bench for the 2-input cell BIST initiator
module tb_gf180mcu_fd_sc_mcu9t5v0__in2_bist;

    logic       clk = 1'b0;
    logic       rn  = 1'b0;

    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [3:0] truth_a = 4'b0000;
    logic [1:0] zmode_a = 2'd0;
    logic       z_a;
    logic       a1_a, a2_a, busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [1:0] fvec_a;

    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] truth_b = 4'b0000;
    logic       z_b;
    logic       a1_b, a2_b, busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [1:0] fvec_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Cell-under-test models: 0 AND2, 1 stuck-at-0, 2 NAND2, 3 XOR2
    always_comb begin
        case (zmode_a)
            2'd0:    z_a = a1_a & a2_a;
            2'd1:    z_a = 1'b0;
            2'd2:    z_a = ~(a1_a & a2_a);
            default: z_a = a1_a ^ a2_a;
        endcase
    end
    assign z_b = ~(a1_b & a2_b);

    gf180mcu_fd_sc_mcu9t5v0__in2_bist #(.SETTLE(1), .PASSES(1), .ERR_W(4)) u_a (
        .CLK(clk), .RN(rn), .START(start_a), .ABORT(abort_a), .TRUTH(truth_a), .Z(z_a),
        .A1(a1_a), .A2(a2_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
        .ERR_CNT(err_a), .FAIL_VEC(fvec_a)
    );

    gf180mcu_fd_sc_mcu9t5v0__in2_bist #(.SETTLE(0), .PASSES(4), .ERR_W(2)) u_b (
        .CLK(clk), .RN(rn), .START(start_b), .ABORT(abort_b), .TRUTH(truth_b), .Z(z_b),
        .A1(a1_b), .A2(a2_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
        .ERR_CNT(err_b), .FAIL_VEC(fvec_b)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {A1,A2,BUSY,DONE,PASS} of instance A
    function automatic logic [4:0] st_a();
        return {a1_a, a2_a, busy_a, done_a, pass_a};
    endfunction

    task automatic start_pulse_a(input logic [3:0] t);
        truth_a = t;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("reset_ctl_a", {27'd0, st_a()}, 32'd0);
        chk("reset_err_a", {26'd0, err_a, fvec_a}, 32'd0);
        chk("reset_b", {22'd0, a1_b, a2_b, busy_b, done_b, pass_b, err_b, fvec_b}, 32'd0);
        rn = 1'b1;
        tick();

        // 1: AND2 good cell, each vector held two cycles
        zmode_a = 2'd0;
        start_pulse_a(4'b1000);
        chk("t1_e0", {27'd0, st_a()}, 32'b00100);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t1_vec_k%0d", k), {29'd0, a1_a, a2_a, done_a}, {29'd0, 2'(k / 2), 1'b0});
        end
        tick();
        chk("t1_done", {27'd0, st_a()}, 32'b00011);
        chk("t1_err", {28'd0, err_a}, 32'd0);

        // DONE state frozen while Z changes
        zmode_a = 2'd2;
        tick(3);
        chk("done_frozen", {27'd0, st_a()}, 32'b00011);

        // 2: stuck-at-0 cell
        zmode_a = 2'd1;
        start_pulse_a(4'b1000);
        tick(7);
        chk("t2_not_done", {31'd0, done_a}, 32'd0);
        tick();
        chk("t2_done", {27'd0, st_a()}, 32'b00010);
        chk("t2_err", {26'd0, err_a, fvec_a}, {26'd0, 4'd1, 2'b11});

        // 4: reset mid-run then clean run
        zmode_a = 2'd0;
        start_pulse_a(4'b1000);
        tick(5);
        rn = 1'b0;
        #1;
        chk("t4_async_rst", {21'd0, st_a(), err_a, fvec_a}, 32'd0);
        tick();
        rn = 1'b1;
        start_pulse_a(4'b1000);
        tick(8);
        chk("t4_clean", {27'd0, st_a()}, 32'b00011);
        chk("t4_err", {26'd0, err_a, fvec_a}, 32'd0);

        // 5a: START while busy ignored
        start_pulse_a(4'b1000);
        tick(2);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(4);
        chk("t5_not_done", {31'd0, done_a}, 32'd0);
        tick();
        chk("t5_done", {27'd0, st_a()}, 32'b00011);

        // 5b: ABORT mid-run keeps error count and first failing vector
        zmode_a = 2'd1;
        start_pulse_a(4'b1111);
        tick(3);
        chk("t5_prabort_err", {28'd0, err_a}, 32'd1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("t5_abort", {27'd0, st_a()}, 32'd0);
        chk("t5_abort_keep", {26'd0, err_a, fvec_a}, {26'd0, 4'd1, 2'b00});
        tick(2);
        chk("t5_idle_hold", {27'd0, st_a()}, 32'd0);

        // 5c: START and ABORT together in IDLE
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        tick();
        chk("t5_start_abort", {27'd0, st_a()}, 32'd0);

        // 6: XOR2, two back-to-back runs
        zmode_a = 2'd3;
        start_pulse_a(4'b0110);
        tick(8);
        chk("t6_run1", {27'd0, st_a()}, 32'b00011);
        start_pulse_a(4'b0110);
        chk("t6_restart", {21'd0, st_a(), err_a, fvec_a}, {21'd0, 5'b00100, 6'd0});
        tick(8);
        chk("t6_run2", {27'd0, st_a()}, 32'b00011);
        chk("t6_err", {26'd0, err_a, fvec_a}, 32'd0);

        // 3: NAND2 cell against AND2 table, four passes, saturating 2-bit counter
        truth_b = 4'b1000;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("t3_e0", {29'd0, busy_b, a1_b, a2_b}, 32'b100);
        tick();
        chk("t3_first", {28'd0, err_b, fvec_b}, {28'd0, 2'd1, 2'b00});
        tick(14);
        chk("t3_not_done", {31'd0, done_b}, 32'd0);
        tick();
        chk("t3_done", {27'd0, a1_b, a2_b, busy_b, done_b, pass_b}, 32'b00010);
        chk("t3_sat", {28'd0, err_b, fvec_b}, {28'd0, 2'd3, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
